// File: rtl/sgd_pkg.sv
`default_nettype none
// ============================================================================
// sgd_pkg : FSM state type, default shape constants and fixed-point helpers
// Rev 1.0
// ============================================================================
package sgd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic int elem_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NELEM = 784 * 10;
  localparam int AW    = elem_aw(NELEM);

  // Round half up at bit FRAC, then clamp to a signed w-bit range.
  function automatic logic signed [127:0] sat_round(input logic signed [127:0] prod,
                                                    input int frac, input int w);
    logic signed [127:0] v;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    v = prod;
    if (frac > 0) v = (prod + (128'sd1 <<< (frac - 1))) >>> frac;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sgd_theta_update_if.sv
`default_nettype none
// ============================================================================
// sgd_theta_update_if : control, gradient, read-back and output stream bundle
// Rev 1.0
// ============================================================================
interface sgd_theta_update_if #(
  parameter int W      = 32,
  parameter int ITER_W = 11,
  parameter int AW     = 13
);
  logic              i_start;
  logic [W-1:0]      i_cfg_lr;
  logic [ITER_W-1:0] i_cfg_max_iter;
  logic [W-1:0]      i_grad_data;
  logic              i_grad_stb;
  logic              o_grad_ack;
  logic [AW-1:0]     i_theta_rd_addr;
  logic [W-1:0]      o_theta_rd_data;
  logic [W-1:0]      o_out_data;
  logic              o_out_stb;
  logic              i_out_ack;
  logic              o_out_last;
  logic              o_busy;
  logic              o_pass_done;
  logic [ITER_W-1:0] o_iter_count;
  logic              o_train_done;

  modport slave (
    input  i_start, i_cfg_lr, i_cfg_max_iter, i_grad_data, i_grad_stb,
           i_theta_rd_addr, i_out_ack,
    output o_grad_ack, o_theta_rd_data, o_out_data, o_out_stb, o_out_last,
           o_busy, o_pass_done, o_iter_count, o_train_done
  );

  modport master (
    output i_start, i_cfg_lr, i_cfg_max_iter, i_grad_data, i_grad_stb,
           i_theta_rd_addr, i_out_ack,
    input  o_grad_ack, o_theta_rd_data, o_out_data, o_out_stb, o_out_last,
           o_busy, o_pass_done, o_iter_count, o_train_done
  );
endinterface
`default_nettype wire

// File: rtl/fxp_mul_round.sv
`default_nettype none
// ============================================================================
// fxp_mul_round : registered signed Q-format multiply with round-half-up/sat
// Rev 1.0
// ============================================================================
module fxp_mul_round
  import sgd_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int TW   = 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 i_flush,
  input  wire logic                 i_valid,
  input  wire logic signed [W-1:0]  i_a,
  input  wire logic signed [W-1:0]  i_b,
  input  wire logic [TW-1:0]        i_tag,
  output logic                      o_valid,
  output logic signed [W-1:0]       o_rnd,
  output logic [TW-1:0]             o_tag
);

  logic signed [2*W-1:0] w_prod;

  assign w_prod = (2*W)'(i_a) * (2*W)'(i_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_rnd   <= '0;
      o_tag   <= '0;
    end else begin
      o_valid <= i_valid && !i_flush;
      if (i_valid) begin
        o_rnd <= W'(sat_round(128'(w_prod), FRAC, W));
        o_tag <= i_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sgd_theta_update.sv
`default_nettype none
// ============================================================================
// sgd_theta_update : Theta store, pipelined SGD update and final stream-out
// Rev 1.0
// ============================================================================
module sgd_theta_update
  import sgd_pkg::*;
#(
  parameter int ROWS   = 784,
  parameter int COLS   = 10,
  parameter int W      = 32,
  parameter int FRAC   = 16,
  parameter int ITER_W = 11
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  sgd_theta_update_if.slave  s_bus
);

  localparam int C_NELEM = ROWS * COLS;
  localparam int C_AW    = elem_aw(C_NELEM);

  state_t                r_state;
  state_t                w_next;
  logic [C_AW-1:0]       r_addr;
  logic [ITER_W-1:0]     r_iter;
  logic [W-1:0]          r_lr;
  logic [ITER_W-1:0]     r_max_iter;
  logic                  r_drain;
  logic                  r_pass_done;
  logic signed [W-1:0]   r_theta [C_NELEM];

  logic                  w_accept;
  logic                  w_last_elem;
  logic                  w_last_pass;
  logic                  w_out_xfer;
  logic                  w_grad_ack;
  logic                  w_out_stb;
  logic                  w_busy;
  logic                  w_train_done;

  logic                  w_s1_valid;
  logic signed [W-1:0]   w_s1_rnd;
  logic [C_AW-1:0]       w_s1_addr;
  logic signed [W-1:0]   w_theta_cur;
  logic signed [W:0]     w_diff;
  logic signed [W-1:0]   w_s2_sat;

  assign w_accept    = (r_state == ST_UPDATE) && s_bus.i_grad_stb;
  assign w_last_elem = (r_addr == C_AW'(C_NELEM - 1));
  assign w_last_pass = (({1'b0, r_iter} + 1'b1) == {1'b0, r_max_iter});
  assign w_out_xfer  = (r_state == ST_OUTPUT) && s_bus.i_out_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (s_bus.i_start) begin
      w_next = ST_CLEAR;
    end else begin
      case (r_state)
        ST_IDLE:   w_next = ST_IDLE;
        ST_CLEAR:  w_next = (r_max_iter == '0) ? ST_OUTPUT : ST_UPDATE;
        ST_UPDATE: if (w_accept && w_last_elem) w_next = ST_DRAIN;
        ST_DRAIN:  if (r_drain) w_next = w_last_pass ? ST_OUTPUT : ST_UPDATE;
        ST_OUTPUT: if (w_out_xfer && w_last_elem) w_next = ST_DONE;
        ST_DONE:   w_next = ST_DONE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_grad_ack   = 1'b0;
    w_out_stb    = 1'b0;
    w_busy       = 1'b0;
    w_train_done = 1'b0;
    case (r_state)
      ST_CLEAR:  w_busy = 1'b1;
      ST_UPDATE: begin
        w_busy     = 1'b1;
        w_grad_ack = 1'b1;
      end
      ST_DRAIN:  w_busy = 1'b1;
      ST_OUTPUT: begin
        w_busy    = 1'b1;
        w_out_stb = 1'b1;
      end
      ST_DONE:   w_train_done = 1'b1;
      default:   w_busy = 1'b0;
    endcase
  end

  // The second DRAIN cycle closes the pass: the last S2 write has landed by then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_iter      <= '0;
      r_lr        <= '0;
      r_max_iter  <= '0;
      r_drain     <= 1'b0;
      r_pass_done <= 1'b0;
    end else begin
      r_pass_done <= 1'b0;
      if (s_bus.i_start) begin
        r_lr       <= s_bus.i_cfg_lr;
        r_max_iter <= s_bus.i_cfg_max_iter;
        r_addr     <= '0;
        r_drain    <= 1'b0;
      end else begin
        case (r_state)
          ST_CLEAR: begin
            r_iter <= '0;
            r_addr <= '0;
          end
          ST_UPDATE: if (w_accept && !w_last_elem) r_addr <= r_addr + 1'b1;
          ST_DRAIN: begin
            r_drain <= ~r_drain;
            if (r_drain) begin
              r_pass_done <= 1'b1;
              r_iter      <= (r_iter == '1) ? r_iter : r_iter + 1'b1;
              r_addr      <= '0;
            end
          end
          ST_OUTPUT: if (w_out_xfer && !w_last_elem) r_addr <= r_addr + 1'b1;
          default: r_drain <= 1'b0;
        endcase
      end
    end
  end

  fxp_mul_round #(
    .W    (W),
    .FRAC (FRAC),
    .TW   (C_AW)
  ) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (s_bus.i_start),
    .i_valid (w_accept),
    .i_a     (r_lr),
    .i_b     (s_bus.i_grad_data),
    .i_tag   (r_addr),
    .o_valid (w_s1_valid),
    .o_rnd   (w_s1_rnd),
    .o_tag   (w_s1_addr)
  );

  assign w_theta_cur = r_theta[w_s1_addr];
  assign w_diff      = {w_theta_cur[W-1], w_theta_cur} - {w_s1_rnd[W-1], w_s1_rnd};

  always_comb begin
    w_s2_sat = w_diff[W-1:0];
    if (w_diff[W] != w_diff[W-1])
      w_s2_sat = w_diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  // Weight storage has no reset; CLEAR zeroes it whenever training starts.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      for (int i = 0; i < C_NELEM; i++) r_theta[i] <= '0;
    end else if (w_s1_valid && !s_bus.i_start) begin
      r_theta[w_s1_addr] <= w_s2_sat;
    end
  end

  assign s_bus.o_grad_ack      = w_grad_ack;
  assign s_bus.o_theta_rd_data = r_theta[s_bus.i_theta_rd_addr];
  assign s_bus.o_out_stb       = w_out_stb;
  assign s_bus.o_out_data      = w_out_stb ? r_theta[r_addr] : '0;
  assign s_bus.o_out_last      = w_out_stb && w_last_elem;
  assign s_bus.o_busy          = w_busy;
  assign s_bus.o_pass_done     = r_pass_done;
  assign s_bus.o_iter_count    = r_iter;
  assign s_bus.o_train_done    = w_train_done;

endmodule
`default_nettype wire

// File: doc/sgd_theta_update.md
Name: sgd_theta_update

Overview:
Parametrised fixed-point weight store and SGD updater for the logistic-regression training loop. Holds Theta (ROWS x COLS, row-major) and applies theta <= theta - lr*grad to one gradient element per accepted beat. It counts passes up to a configurable iteration limit, then streams the final Theta out. It succeeds the float Theta update / write-out path, adding configurable width, fraction, shape, iteration count, backpressure, rounding and saturation.

Parameters:
ROWS, 784, Theta rows (features)
COLS, 10, Theta columns (classes)
W, 32, signed data width of theta, grad and lr
FRAC, 16, fractional bits of the Qx.FRAC format
ITER_W, 11, width of the iteration counter and limit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  pulse; clear Theta, latch cfg, begin training
cfg_lr  in  W  learning rate, signed Q.FRAC, latched on start
cfg_max_iter  in  ITER_W  number of passes, latched on start
grad_data  in  W  gradient element, row-major order
grad_stb  in  1  grad_data valid
grad_ack  out  1  element accepted when grad_stb&&grad_ack
theta_rd_addr  in  clog2(ROWS*COLS)  forward-pass read address
theta_rd_data  out  W  combinational read of stored theta
out_data  out  W  final Theta element
out_stb  out  1  out_data valid
out_ack  in  1  consumer accepts when out_stb&&out_ack
out_last  out  1  high with final element
busy  out  1  high in CLEAR..OUTPUT
pass_done  out  1  one-cycle pulse per completed pass
iter_count  out  ITER_W  completed passes
train_done  out  1  high after output stream completes, until start

Behaviour:
- Reset (rst low, async): state IDLE. grad_ack, out_stb, out_last, busy, pass_done and train_done are 0. iter_count and out_data are 0. The Theta array is not reset.
- States: IDLE, CLEAR, UPDATE, DRAIN, OUTPUT, DONE.
- start in any state (including mid-pass) aborts and goes to CLEAR; the in-flight pipeline is discarded.
- CLEAR (1 cycle): all Theta = 0, iter_count = 0, cfg latched, elem address = 0. Next state is OUTPUT if the latched max_iter == 0, else UPDATE.
- UPDATE: grad_ack = 1. Each beat feeds a 2-stage pipeline:
  - S1: prod = lr*grad (2W signed); rounded = (prod + 2^(FRAC-1)) >>> FRAC.
  - S2: diff = theta[a] - rounded, computed at W+1 bits and saturated to [-2^(W-1), 2^(W-1)-1], then written to theta[a].
  - The address increments per accepted beat. After beat ROWS*COLS-1, grad_ack drops in the next cycle and the state moves to DRAIN.
- Gaps in grad_stb stall the address only; the pipeline still advances.
- DRAIN: lasts until the pipeline is empty (2 cycles).
  - Then pass_done pulses and iter_count increments; the address resets to 0.
  - If iter_count+1 == max_iter, go to OUTPUT, else go to UPDATE.
  - Write latency: element visible on theta_rd_data 2 cycles after acceptance.
- OUTPUT: out_stb = 1, out_data = theta[addr]; data held stable while !out_ack. Address advances on each transfer. out_last = 1 when addr == ROWS*COLS-1. After the last transfer, go to DONE.
- DONE: train_done = 1, busy = 0. Remains until start.
- theta_rd_data is valid in all states.
- In OUTPUT and DONE, grad_stb is ignored (grad_ack = 0).
- iter_count saturates at 2^ITER_W-1.

Decomposition:
- Package sgd_pkg: state enum, localparams NELEM = ROWS*COLS and AW = clog2(NELEM), and a function sat_round(prod) implementing round-half-up plus saturation.
- One sub-module, fxp_mul_round: 1-stage registered signed multiply with rounding (S1), reusable by the mat_* blocks.

Test Plan:
Use ROWS=2, COLS=2, W=16, FRAC=8 for all cases.
- Basic pass: start with lr=0x0080, max_iter=1; grads 0x0100, 0x0200, 0xFF00, 0x0000 -> pass_done once; out stream FF80, FF00, 0080, 0000; out_last on the 4th element; train_done=1.
- Rounding: lr=0x0001, grad=0x0080 -> prod 0x80 rounds to 1 -> theta=0xFFFF; grad=0x007F -> 0 -> theta unchanged.
- Saturation: lr=0x7FFF, grad=0x7FFF, max_iter=3 -> every element is 0x8000 after pass 2 and stays 0x8000 after pass 3.
- Backpressure: grad_stb toggled every other cycle and out_ack low for 5 cycles mid-stream -> no lost or duplicated element; out_data stable while stalled.
- Abort/reset: assert start after 2 beats of pass 1 -> theta_rd_data reads 0 at all addresses and iter_count=0. rst low mid-OUTPUT -> all outputs 0 immediately, state IDLE.
- Zero iterations: max_iter=0 -> CLEAR then OUTPUT streams four 0x0000 with no pass_done.
